hls_method_sequencer: RTL

Controller that exercises one synthesized method through its req/busy/return handshake. On `start` it waits a settling delay, then issues `num_runs` back-to-back method calls, samples the return flag after each call, and counts passes and failures. Per-phase watchdogs catch a method that never acknowledges or never finishes. It sits between a top-level bench or host CSR block and a generated module's `<method>_req` / `<method>_busy` / `<method>_return` ports.

---
 rtl/hls_seq_pkg.sv | 18 +
 rtl/seq_watchdog.sv | 35 +++
 rtl/hls_method_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/hls_seq_pkg.sv
// Shared types and default timing constants for the HLS method-call sequencer.
package hls_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DELAY     = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_CHECK     = 3'd5,
    ST_FINISH    = 3'd6
  } seq_state_t;

  localparam int unsigned START_DELAY_DEF = 100;
  localparam int unsigned ACK_TIMEOUT_DEF = 16;
  localparam int unsigned RUN_TIMEOUT_DEF = 200000000;

endpackage

// File: rtl/seq_watchdog.sv
// Loadable down-counter shared by the settle delay and both handshake watchdogs.
// expired is high whenever the count sits at zero; load wins over enable.
module seq_watchdog #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] value,
  input  logic          enable,
  output logic          expired
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/hls_method_sequencer.sv
// Drives a synthesized method through num_runs req/busy/return handshakes,
// tallying passes and failures, with watchdogs on the acknowledge and run phases.
module hls_method_sequencer
  import hls_seq_pkg::*;
#(
  parameter int unsigned START_DELAY = START_DELAY_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int unsigned RUN_TIMEOUT = RUN_TIMEOUT_DEF,
  parameter int          CW          = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] num_runs,
  output logic        method_req,
  input  logic        method_busy,
  input  logic        method_return,
  output logic        busy,
  output logic        done,
  output logic [15:0] pass_count,
  output logic [15:0] fail_count,
  output logic        timeout_flag,
  output logic        all_pass
);

  // Loads are one less than the cycle count: the counter expires on reaching zero.
  localparam logic [CW-1:0] DELAY_LOAD = CW'(START_DELAY - 1);
  localparam logic [CW-1:0] ACK_LOAD   = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] RUN_LOAD   = CW'(RUN_TIMEOUT - 1);

  seq_state_t  state_q, state_d;
  logic [15:0] runs_q, runs_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] pass_q, pass_d;
  logic [15:0] fail_q, fail_d;
  logic        to_q, to_d;
  logic        allp_q, allp_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ret_q, ret_d;

  logic          wd_load;
  logic [CW-1:0] wd_value;
  logic          wd_en;
  logic          wd_expired;

  seq_watchdog #(.CW(CW)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .load    (wd_load),
    .value   (wd_value),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    runs_d   = runs_q;
    idx_d    = idx_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    to_d     = to_q;
    allp_d   = allp_q;
    busy_d   = busy_q;
    ret_d    = ret_q;
    req_d    = 1'b0;
    done_d   = 1'b0;
    wd_load  = 1'b0;
    wd_value = '0;
    wd_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          runs_d   = num_runs;
          idx_d    = '0;
          pass_d   = '0;
          fail_d   = '0;
          to_d     = 1'b0;
          allp_d   = 1'b0;
          busy_d   = 1'b1;
          wd_load  = 1'b1;
          wd_value = DELAY_LOAD;
          state_d  = ST_DELAY;
        end
      end
      ST_DELAY: begin
        wd_en = 1'b1;
        if (wd_expired) begin
          if (runs_q == '0) begin
            state_d = ST_FINISH;
          end else begin
            req_d   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Busy coincident with the request is not treated as the acknowledge.
        wd_load  = 1'b1;
        wd_value = ACK_LOAD;
        state_d  = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        wd_en = 1'b1;
        if (method_busy) begin
          wd_load  = 1'b1;
          wd_value = RUN_LOAD;
          state_d  = ST_WAIT_DONE;
        end else if (wd_expired) begin
          to_d    = 1'b1;
          fail_d  = fail_q + 16'd1;
          state_d = ST_FINISH;
        end
      end
      ST_WAIT_DONE: begin
        wd_en = 1'b1;
        if (!method_busy) begin
          ret_d   = method_return;
          state_d = ST_CHECK;
        end else if (wd_expired) begin
          to_d    = 1'b1;
          fail_d  = fail_q + 16'd1;
          state_d = ST_FINISH;
        end
      end
      ST_CHECK: begin
        if (ret_q) begin
          pass_d = pass_q + 16'd1;
        end else begin
          fail_d = fail_q + 16'd1;
        end
        idx_d = idx_q + 16'd1;
        if (idx_d == runs_q) begin
          state_d = ST_FINISH;
        end else begin
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        allp_d  = (pass_q == runs_q) && (runs_q != '0) && !to_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      runs_q  <= '0;
      idx_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      to_q    <= 1'b0;
      allp_q  <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      runs_q  <= runs_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
      allp_q  <= allp_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ret_q   <= ret_d;
    end
  end

  assign method_req   = req_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass_count   = pass_q;
  assign fail_count   = fail_q;
  assign timeout_flag = to_q;
  assign all_pass     = allp_q;

endmodule
